ft_recovery_ctrl: RTL and testbench

FT_RECOVERY_CTRL -- requirements
Module: ft_recovery_ctrl

---
 rtl/ft_pkg.sv | 9 +
 rtl/ft_sat_counter.sv | 13 +
 rtl/ft_recovery_ctrl.sv | 89 ++++++++
 tb/tb_ft_recovery_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// ft_pkg: shared state encoding and default constants for the fault-tolerant recovery controller
package ft_pkg;
   typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_RESTORE, ST_FATAL} state_t;
   localparam logic [31:0] DEF_BOOT_ADDR    = 32'h0000_0000;
   localparam int          DEF_DRAIN_CYCLES = 2;
   localparam int          DEF_MAX_RETRY    = 3;
   localparam int          DEF_COMMIT_CLEAR = 4;
   localparam int          DEF_CNT_W        = 8;
endpackage

// File: rtl/ft_sat_counter.sv
// ft_sat_counter: saturating up-counter with synchronous clear
module ft_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);
   // clear wins over increment; count holds once it reaches all-ones
   always_ff @(posedge clk_i)
      count <= clr ? '0 : (inc && count != '1) ? count + 1'b1 : count;
endmodule

// File: rtl/ft_recovery_ctrl.sv
// ft_recovery_ctrl: checkpoint/rollback sequencer for a lockstep core pair
module ft_recovery_ctrl
   import ft_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR    = DEF_BOOT_ADDR,
   parameter int          DRAIN_CYCLES = DEF_DRAIN_CYCLES,
   parameter int          MAX_RETRY    = DEF_MAX_RETRY,
   parameter int          COMMIT_CLEAR = DEF_COMMIT_CLEAR,
   parameter int          CNT_W        = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             error_i,
   input  logic             commit_i,
   input  logic [31:0]      commit_pc_i,
   output logic             halt_o,
   output logic             restore_o,
   output logic [31:0]      restore_pc_o,
   output logic             busy_o,
   output logic             fatal_o,
   output logic [CNT_W-1:0] error_count_o
);
   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
   localparam logic [3:0] RETRY_MAX  = 4'(MAX_RETRY);
   localparam logic [8:0] CLEAR_AT   = 9'(COMMIT_CLEAR);

   state_t      state, state_nx;
   logic [3:0]  retry_cnt, drain_cnt;
   logic [7:0]  clean_cnt;
   logic        acc_err, clean_commit, clean_hit, retry_full;

   // errors and commits are only observed while running; an error masks a same-cycle commit
   assign acc_err      = state == ST_RUN && error_i;
   assign clean_commit = state == ST_RUN && commit_i && !error_i;
   assign clean_hit    = {1'b0, clean_cnt} + 9'd1 == CLEAR_AT;
   assign retry_full   = retry_cnt == RETRY_MAX;

   // state register
   always_ff @(posedge clk_i)
      state <= rst_i ? ST_RUN : state_nx;

   // next-state: run -> halt (or fatal once retries are exhausted) -> restore -> run
   always_comb begin
      state_nx = state;
      case (state)
         ST_RUN:     state_nx = acc_err ? (retry_full ? ST_FATAL : ST_HALT) : ST_RUN;
         ST_HALT:    state_nx = drain_cnt == '0 ? ST_RESTORE : ST_HALT;
         ST_RESTORE: state_nx = ST_RUN;
         default:    state_nx = ST_FATAL;
      endcase
   end

   // outputs decoded purely from the registered state
   always_comb begin
      halt_o    = state != ST_RUN;
      busy_o    = state != ST_RUN;
      restore_o = state == ST_RESTORE;
      fatal_o   = state == ST_FATAL;
   end

   // checkpoint, retry/clean bookkeeping and drain timer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         restore_pc_o <= BOOT_ADDR;
         retry_cnt    <= '0;
         clean_cnt    <= '0;
         drain_cnt    <= '0;
      end else if (acc_err) begin
         clean_cnt <= '0;
         if (!retry_full) begin
            retry_cnt <= retry_cnt + 4'd1;
            drain_cnt <= DRAIN_LOAD;
         end
      end else if (clean_commit) begin
         restore_pc_o <= commit_pc_i;
         clean_cnt    <= clean_hit ? '0 : clean_cnt + 8'd1;
         if (clean_hit) retry_cnt <= '0;
      end else if (state == ST_HALT && drain_cnt != '0) begin
         drain_cnt <= drain_cnt - 4'd1;
      end
   end

   ft_sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk_i (clk_i),
      .clr   (rst_i),
      .inc   (acc_err),
      .count (error_count_o)
   );
endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// tb_ft_recovery_ctrl: vector table, directed corner sequences and randomized model comparison
module tb_ft_recovery_ctrl;
   localparam int DRAIN = 2, MAXR = 3, CLR = 4, CW = 8;

   logic          clk_i = 1'b0, rst_i = 1'b0, error_i = 1'b0, commit_i = 1'b0;
   logic [31:0]   commit_pc_i = '0, restore_pc_o;
   logic          halt_o, restore_o, busy_o, fatal_o;
   logic [CW-1:0] error_count_o;

   int checks = 0, errors = 0;

   int          m_left, m_retry, m_clean, m_errs;
   bit          m_fatal;
   logic [31:0] m_cp;

   typedef struct {
      logic r, e, c; logic [31:0] p;
      logic h, rs, f; logic [31:0] pc; logic [7:0] cnt;
   } vec_t;
   vec_t tbl[19];

   ft_recovery_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .error_i(error_i), .commit_i(commit_i),
      .commit_pc_i(commit_pc_i), .halt_o(halt_o), .restore_o(restore_o),
      .restore_pc_o(restore_pc_o), .busy_o(busy_o), .fatal_o(fatal_o),
      .error_count_o(error_count_o)
   );

   always #5 clk_i = ~clk_i;

   // reference: a recovery is a fixed window of DRAIN+1 busy cycles, the last one restoring
   task automatic model(input logic r, e, c, input logic [31:0] p);
      if (r) begin
         m_left = 0; m_retry = 0; m_clean = 0; m_errs = 0; m_fatal = 0; m_cp = 32'h0;
      end else if (m_fatal) begin
      end else if (m_left > 0) m_left--;
      else if (e) begin
         if (m_errs < (1 << CW) - 1) m_errs++;
         m_clean = 0;
         if (m_retry == MAXR) m_fatal = 1;
         else begin m_retry++; m_left = DRAIN + 1; end
      end else if (c) begin
         m_cp = p; m_clean++;
         if (m_clean == CLR) begin m_clean = 0; m_retry = 0; end
      end
   endtask

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, x);
      end
   endtask

   task automatic step(input logic r, e, c, input logic [31:0] p);
      rst_i = r; error_i = e; commit_i = c; commit_pc_i = p;
      @(posedge clk_i);
      model(r, e, c, p);
      #1;
   endtask

   task automatic chk_model(input string t);
      chk({t, ".halt"}, 32'(halt_o), 32'(m_fatal || m_left > 0));
      chk({t, ".busy"}, 32'(busy_o), 32'(m_fatal || m_left > 0));
      chk({t, ".restore"}, 32'(restore_o), 32'(!m_fatal && m_left == 1));
      chk({t, ".fatal"}, 32'(fatal_o), 32'(m_fatal));
      chk({t, ".pc"}, restore_pc_o, m_cp);
      chk({t, ".cnt"}, 32'(error_count_o), 32'(m_errs));
   endtask

   task automatic mstep(input string t, input logic r, e, c, input logic [31:0] p);
      step(r, e, c, p);
      chk_model(t);
   endtask

   task automatic recover(input string t);
      mstep(t, 0, 1, 0, 0);
      repeat (DRAIN + 1) mstep(t, 0, 0, 0, 0);
   endtask

   initial begin
      //           r  e  c  pc      halt rst fat pc      cnt
      tbl[0]  = '{1, 0, 0, 32'h00, 0, 0, 0, 32'h00, 0};
      tbl[1]  = '{0, 0, 1, 32'h80, 0, 0, 0, 32'h80, 0};
      tbl[2]  = '{0, 0, 1, 32'h84, 0, 0, 0, 32'h84, 0};
      tbl[3]  = '{0, 0, 1, 32'h88, 0, 0, 0, 32'h88, 0};
      tbl[4]  = '{1, 0, 0, 32'h00, 0, 0, 0, 32'h00, 0};
      tbl[5]  = '{0, 0, 1, 32'h84, 0, 0, 0, 32'h84, 0};
      tbl[6]  = '{0, 1, 0, 32'h00, 1, 0, 0, 32'h84, 1};
      tbl[7]  = '{0, 0, 1, 32'hAA, 1, 0, 0, 32'h84, 1};
      tbl[8]  = '{0, 1, 0, 32'h00, 1, 1, 0, 32'h84, 1};
      tbl[9]  = '{0, 0, 0, 32'h00, 0, 0, 0, 32'h84, 1};
      tbl[10] = '{0, 0, 1, 32'h8C, 0, 0, 0, 32'h8C, 1};
      tbl[11] = '{0, 1, 1, 32'h90, 1, 0, 0, 32'h8C, 2};
      tbl[12] = '{0, 0, 0, 32'h00, 1, 0, 0, 32'h8C, 2};
      tbl[13] = '{0, 0, 0, 32'h00, 1, 1, 0, 32'h8C, 2};
      tbl[14] = '{0, 0, 0, 32'h00, 0, 0, 0, 32'h8C, 2};
      tbl[15] = '{0, 1, 0, 32'h00, 1, 0, 0, 32'h8C, 3};
      tbl[16] = '{0, 0, 0, 32'h00, 1, 0, 0, 32'h8C, 3};
      tbl[17] = '{1, 0, 0, 32'h00, 0, 0, 0, 32'h00, 0};
      tbl[18] = '{0, 0, 0, 32'h00, 0, 0, 0, 32'h00, 0};
      for (int i = 0; i < 19; i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         step(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].p);
         chk({t, ".halt"}, 32'(halt_o), 32'(tbl[i].h));
         chk({t, ".busy"}, 32'(busy_o), 32'(tbl[i].h));
         chk({t, ".restore"}, 32'(restore_o), 32'(tbl[i].rs));
         chk({t, ".fatal"}, 32'(fatal_o), 32'(tbl[i].f));
         chk({t, ".pc"}, restore_pc_o, tbl[i].pc);
         chk({t, ".cnt"}, 32'(error_count_o), 32'(tbl[i].cnt));
      end

      // four errors with too few clean commits between them end in a held fatal
      mstep("fatal.rst", 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         recover("fatal.rec");
         mstep("fatal.commit", 0, 0, 1, 32'h100 + 32'(4 * k));
      end
      mstep("fatal.err4", 0, 1, 0, 0);
      chk("fatal.flag", 32'(fatal_o), 32'd1);
      for (int k = 0; k < 6; k++) mstep("fatal.hold", 0, k[0], 1, 32'h200);
      chk("fatal.cnt4", 32'(error_count_o), 32'd4);
      chk("fatal.halt_held", 32'(halt_o), 32'd1);
      chk("fatal.pc_held", restore_pc_o, 32'h108);

      // clean commits clear the retry budget so three more errors stay recoverable
      mstep("clear.rst", 1, 0, 0, 0);
      recover("clear.rec0");
      for (int k = 0; k < CLR; k++) mstep("clear.commit", 0, 0, 1, 32'h300 + 32'(4 * k));
      for (int k = 0; k < 3; k++) recover("clear.rec");
      chk("clear.nofatal", 32'(fatal_o), 32'd0);
      chk("clear.cnt4", 32'(error_count_o), 32'd4);

      // error counter saturates at all-ones
      mstep("sat.rst", 1, 0, 0, 0);
      for (int k = 0; k < 260; k++) begin
         recover("sat.rec");
         for (int j = 0; j < CLR; j++) mstep("sat.commit", 0, 0, 1, 32'(k * 16 + j * 4));
      end
      chk("sat.cnt", 32'(error_count_o), 32'hFF);

      // randomized traffic against the reference model
      mstep("rnd.rst", 1, 0, 0, 0);
      for (int k = 0; k < 4000; k++)
         mstep("rnd", $urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 1) == 1, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
